// File: rtl/mastermind_game_ctrl.sv
`default_nettype none
// mastermind_game_ctrl - Mastermind sequencer: game credits, rounds, scorer handshake, VGA strobes.
// Revision 1.0
module mastermind_game_ctrl (
  input  logic        CLOCK_50,
  input  logic        reset_L,
  input  logic        addGame,
  input  logic        startGame,
  input  logic        loadMaster,
  input  logic [11:0] masterIn,
  input  logic        gradeIt,
  input  logic [11:0] guessIn,
  input  logic        scoreAck,
  input  logic [3:0]  znarlyIn,
  input  logic [3:0]  zoodIn,
  output logic        scoreReq,
  output logic [11:0] masterPattern,
  output logic [11:0] guessOut,
  output logic [3:0]  numGames,
  output logic [3:0]  roundNumber,
  output logic [3:0]  znarly,
  output logic [3:0]  zood,
  output logic        loadNumGames,
  output logic        clearGame,
  output logic        loadGuess,
  output logic        loadZnarlyZood,
  output logic        displayMasterPattern,
  output logic        gameOver,
  output logic        gameWon
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MASTER = 3'd1,
    S_CLEAR  = 3'd2,
    S_GUESS  = 3'd3,
    S_SCORE  = 3'd4,
    S_UPDATE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] master_q, master_d, guess_q, guess_d;
  logic [3:0]  games_q, games_d, round_q, round_d;
  logic [3:0]  znarly_q, znarly_d, zood_q, zood_d;
  logic        req_q, req_d, lng_q, lng_d, clr_q, clr_d;
  logic        lg_q, lg_d, lzz_q, lzz_d;
  logic        disp_q, disp_d, over_q, over_d, won_q, won_d;
  logic        add_ok, start_ok;

  // Shape codes 0 and 7 are unused, so a pattern holding either is rejected.
  function automatic logic pattern_ok(input logic [11:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (p[3*i +: 3] == 3'd0 || p[3*i +: 3] == 3'd7) ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    guess_d  = guess_q;
    games_d  = games_q;
    round_d  = round_q;
    znarly_d = znarly_q;
    zood_d   = zood_q;
    disp_d   = disp_q;
    over_d   = over_q;
    won_d    = won_q;
    req_d    = 1'b0;
    clr_d    = 1'b0;
    lg_d     = 1'b0;
    lzz_d    = 1'b0;

    add_ok   = addGame && (games_q != 4'd7);
    start_ok = startGame && (state_q == S_IDLE || state_q == S_DONE) && (games_q != 4'd0);

    if (add_ok && !start_ok)      games_d = games_q + 4'd1;
    else if (start_ok && !add_ok) games_d = games_q - 4'd1;
    lng_d = (games_d != games_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_MASTER;
          over_d  = 1'b0;
          won_d   = 1'b0;
          disp_d  = 1'b0;
          round_d = 4'd0;
        end
      end
      S_MASTER: begin
        if (loadMaster && pattern_ok(masterIn)) begin
          state_d  = S_CLEAR;
          master_d = masterIn;
          round_d  = 4'd1;
          clr_d    = 1'b1;
        end
      end
      S_CLEAR: state_d = S_GUESS;
      S_GUESS: begin
        if (gradeIt && pattern_ok(guessIn)) begin
          state_d = S_SCORE;
          guess_d = guessIn;
          req_d   = 1'b1;
          lg_d    = 1'b1;
        end
      end
      S_SCORE: begin
        if (scoreAck) begin
          state_d  = S_UPDATE;
          znarly_d = znarlyIn;
          zood_d   = zoodIn;
          lzz_d    = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_UPDATE: begin
        if (znarly_q == 4'd4) begin
          state_d = S_DONE;
          over_d  = 1'b1;
          disp_d  = 1'b1;
          won_d   = 1'b1;
        end else if (round_q == 4'd8) begin
          state_d = S_DONE;
          over_d  = 1'b1;
          disp_d  = 1'b1;
        end else begin
          state_d = S_GUESS;
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      master_q <= '0;
      guess_q  <= '0;
      games_q  <= '0;
      round_q  <= '0;
      znarly_q <= '0;
      zood_q   <= '0;
      req_q    <= 1'b0;
      lng_q    <= 1'b0;
      clr_q    <= 1'b0;
      lg_q     <= 1'b0;
      lzz_q    <= 1'b0;
      disp_q   <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      master_q <= master_d;
      guess_q  <= guess_d;
      games_q  <= games_d;
      round_q  <= round_d;
      znarly_q <= znarly_d;
      zood_q   <= zood_d;
      req_q    <= req_d;
      lng_q    <= lng_d;
      clr_q    <= clr_d;
      lg_q     <= lg_d;
      lzz_q    <= lzz_d;
      disp_q   <= disp_d;
      over_q   <= over_d;
      won_q    <= won_d;
    end
  end

  assign scoreReq             = req_q;
  assign masterPattern        = master_q;
  assign guessOut             = guess_q;
  assign numGames             = games_q;
  assign roundNumber          = round_q;
  assign znarly               = znarly_q;
  assign zood                 = zood_q;
  assign loadNumGames         = lng_q;
  assign clearGame            = clr_q;
  assign loadGuess            = lg_q;
  assign loadZnarlyZood       = lzz_q;
  assign displayMasterPattern = disp_q;
  assign gameOver             = over_q;
  assign gameWon              = won_q;

endmodule
`default_nettype wire
